// File: rtl/pc_pkg.sv
// Shared constants, depth-counter sizing and command priority encoding for
// the program-counter sequencer.
package pc_pkg;

  localparam int PC_ADDR_WIDTH  = 8;
  localparam int PC_STACK_DEPTH = 4;
  localparam int PC_OFFS_WIDTH  = 8;

  // Bits needed to count 0..depth inclusive, so "full" is representable.
  function automatic int depth_cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Commands in ascending priority; exactly one acts per cycle.
  typedef enum logic [2:0] {
    CMD_HOLD,
    CMD_INC,
    CMD_REL,
    CMD_LOAD,
    CMD_RET,
    CMD_CALL,
    CMD_CLR,
    CMD_RST
  } pc_cmd_e;

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO. Push and pop are ignored when full/empty respectively;
// entries above the current depth are stale and never read by the owner.
module pc_ret_stack
  import pc_pkg::*;
#(
  parameter int DATA_WIDTH = PC_ADDR_WIDTH,
  parameter int DEPTH      = PC_STACK_DEPTH
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] top,
  output logic                  full,
  output logic                  empty
);

  localparam int CW = depth_cnt_width(DEPTH);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0]         depth;
  logic [IW-1:0]         wr_ptr;
  logic [IW-1:0]         top_ptr;
  logic [DATA_WIDTH-1:0] mem [1 << IW];

  assign wr_ptr  = IW'(depth);
  assign top_ptr = IW'(depth - CW'(1));
  assign top     = mem[top_ptr];
  assign full    = (depth == CW'(DEPTH));
  assign empty   = (depth == '0);

  // Depth counter; a push wins over a pop if both ever arrive together.
  always_ff @(posedge clk) begin
    if (clr)
      depth <= '0;
    else if (push && !full)
      depth <= depth + CW'(1);
    else if (pop && !empty)
      depth <= depth - CW'(1);
  end

  // Storage write; no reset needed since stale slots are never observed.
  always_ff @(posedge clk) begin
    if (push && !full && !clr)
      mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with absolute/relative branching and a call/return stack.
// Commands are resolved by fixed priority; only the winning command acts.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = PC_ADDR_WIDTH,
  parameter int                    STACK_DEPTH  = PC_STACK_DEPTH,
  parameter int                    OFFS_WIDTH   = PC_OFFS_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  PC_Clr,
  input  logic                  PC_Load,
  input  logic                  PC_Inc,
  input  logic                  PC_Rel,
  input  logic                  PC_Call,
  input  logic                  PC_Ret,
  input  logic [ADDR_WIDTH-1:0] Dest_Reg,
  input  logic [OFFS_WIDTH-1:0] Offset,
  output logic [ADDR_WIDTH-1:0] PC_Out,
  output logic                  Stack_Full,
  output logic                  Stack_Empty,
  output logic                  Stack_Err
);

  pc_cmd_e               cmd;
  logic [ADDR_WIDTH-1:0] pc_q, pc_nxt;
  logic [ADDR_WIDTH-1:0] offs_ext, ret_addr, stack_top;
  logic                  err_q, err_nxt;
  logic                  push, pop, stack_clr;

  assign offs_ext    = ADDR_WIDTH'($signed(Offset));
  assign ret_addr    = pc_q + ADDR_WIDTH'(1);
  assign PC_Out      = pc_q;
  assign Stack_Err   = err_q;

  // Priority decode of the command inputs.
  always_comb begin
    cmd = CMD_HOLD;
    if (Rst)          cmd = CMD_RST;
    else if (PC_Clr)  cmd = CMD_CLR;
    else if (PC_Call) cmd = CMD_CALL;
    else if (PC_Ret)  cmd = CMD_RET;
    else if (PC_Load) cmd = CMD_LOAD;
    else if (PC_Rel)  cmd = CMD_REL;
    else if (PC_Inc)  cmd = CMD_INC;
  end

  // Next PC, error flag and stack controls for the winning command.
  always_comb begin
    pc_nxt    = pc_q;
    err_nxt   = err_q;
    push      = 1'b0;
    pop       = 1'b0;
    stack_clr = 1'b0;
    case (cmd)
      CMD_RST: begin
        pc_nxt    = RESET_VECTOR;
        err_nxt   = 1'b0;
        stack_clr = 1'b1;
      end
      CMD_CLR: begin
        pc_nxt    = '0;
        err_nxt   = 1'b0;
        stack_clr = 1'b1;
      end
      CMD_CALL: begin
        if (Stack_Full) begin
          err_nxt = 1'b1;
        end else begin
          push   = 1'b1;
          pc_nxt = Dest_Reg;
        end
      end
      CMD_RET: begin
        if (Stack_Empty) begin
          err_nxt = 1'b1;
        end else begin
          pop    = 1'b1;
          pc_nxt = stack_top;
        end
      end
      CMD_LOAD: pc_nxt = Dest_Reg;
      CMD_REL:  pc_nxt = pc_q + offs_ext;
      CMD_INC:  pc_nxt = pc_q + ADDR_WIDTH'(1);
      default:  ;
    endcase
  end

  // PC and sticky error registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      pc_q  <= RESET_VECTOR;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_nxt;
      err_q <= err_nxt;
    end
  end

  pc_ret_stack #(
    .DATA_WIDTH (ADDR_WIDTH),
    .DEPTH      (STACK_DEPTH)
  ) u_ret_stack (
    .clk   (Clk),
    .clr   (stack_clr),
    .push  (push),
    .pop   (pop),
    .din   (ret_addr),
    .top   (stack_top),
    .full  (Stack_Full),
    .empty (Stack_Empty)
  );

endmodule
